inet_chksum_stream: RTL
=======================

Name: inet_chksum_stream

Overview:
- Streaming successor to the combinational Internet checksum: accumulates the RFC 1071 ones-complement sum of a packet delivered as DATA_W-bit beats.
- Uses a valid/ready handshake, supports a partial last beat via byte keep, and has a verify mode.
- Sits between a packet source (header builder or receive parser) and logic that inserts or checks the 16-bit checksum field.

Parameters:
DATA_W, 32, beat width in bits; multiple of 16, range 16..128; W = DATA_W/16 words per beat
CNT_W, 16, width of the beat counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  beat offered
in_ready  out  1  block accepts beat
in_data  in  DATA_W  beat; [DATA_W-1:DATA_W-16] is first word (network order)
in_keep  in  DATA_W/8  byte enables, MSB = first byte; honoured on last beat only
in_last  in  1  final beat of packet
verify  in  1  sampled with the last beat: 0 = generate, 1 = check
out_valid  out  1  result available
out_ready  in  1  consumer takes result
checksum  out  16  ~(folded sum)
ok  out  1  verify mode: folded sum == 16'hFFFF; 0 in generate mode
beats  out  CNT_W  beats in the packet, saturating at all-ones

Behaviour:
- Reset (async, immediate):
  - state = ACC, acc = 0, beat counter = 0
  - out_valid = 0, checksum = 0, ok = 0, beats = 0
  - Any partial packet is discarded.
- States:
  - ACC: in_ready = 1, out_valid = 0. A beat is accepted when in_valid && in_ready.
  - DONE: in_ready = 0, out_valid = 1, outputs held stable. On out_ready, go to ACC with acc = 0 and counter = 0.
  - in_ready is registered state decode only; there is no combinational path from out_ready.
- Per accepted beat:
  - Zero the masked bytes: only on last beat, for bytes with keep = 0.
  - Sum the W words plus acc into a 16+clog2(W+1)-bit value.
  - Fold end-around carry twice to 16 bits.
  - Register the result into acc; counter += 1, saturating.
- Last beat accepted at edge N: the result is computed from the final folded value.
  - checksum = ~acc_final
  - ok = verify && (acc_final == 16'hFFFF)
  - beats = count including the last beat
  - Results are registered at edge N, so out_valid = 1 from cycle N+1. Latency is 1 cycle.
- Ones-complement rules:
  - Sum 16'hFFFF stays 16'hFFFF; do not normalise -0 to +0.
  - An all-zero packet yields checksum 16'hFFFF.
- in_keep on non-last beats is ignored; all bytes count. A last beat with keep all zero contributes 0 but is still counted.
- verify is sampled only on the accepted last beat.
- in_valid while in DONE: no acceptance; the source must hold its beat.
- out_ready while out_valid = 0: ignored.
- Counter saturation does not affect the checksum.
- Reset asserted in DONE clears out_valid immediately; the result is lost.

Test Plan:
- Single beat, DATA_W=32: 32'h9D2DC3D5, keep=4'hF, last, verify=0 -> next cycle out_valid=1, checksum=16'h9EFC, ok=0, beats=1.
- IPv4 header, 5 beats: 45000073, 00004000, 40110000, C0A80001, C0A800C7 (last on 5th), verify=0 -> checksum=16'hB861, beats=5. Repeat with beat 3 = 4011B861 and verify=1 -> checksum=16'h0000, ok=1.
- Partial last beat: 32'hABCDEF12, keep=4'b1110, last -> words ABCD + EF00, checksum=16'h6531.
- Edge values:
  - One beat of all zero -> checksum=16'hFFFF.
  - Two beats of 32'hFFFFFFFF -> checksum=16'h0000; verify=1 gives ok=1.
- Backpressure: hold out_ready=0 for 5 cycles after result -> in_ready=0, outputs stable; beat offered meanwhile not accepted. Then out_ready=1 for 1 cycle -> ACC next cycle, held beat accepted, new packet result independent of old one.
- Reset mid-packet: 2 beats of the IPv4 packet, assert rst for 1 cycle, resend full packet -> checksum=16'hB861, beats=5; no out_valid during or after reset until the new last beat.

Source files
------------

// File: rtl/inet_chksum_stream.sv
// Streaming RFC 1071 ones-complement checksum over DATA_W-bit beats with valid/ready.
// Holds checksum/ok/beats after the last beat until the consumer takes them.
module inet_chksum_stream #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DATA_W/8-1:0] in_keep,
   input  logic                in_last,
   input  logic                verify,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [15:0]         checksum,
   output logic                ok,
   output logic [CNT_W-1:0]    beats
);
   localparam int W     = DATA_W / 16;
   localparam int NB    = DATA_W / 8;
   localparam int SUM_W = 16 + $clog2(W + 1);

   typedef enum logic {ST_ACC, ST_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [15:0]       r_checksum;
   logic              r_ok;
   logic [CNT_W-1:0]  r_beats;

   logic              w_accept;
   logic              w_take;
   logic [DATA_W-1:0] w_data_p0;
   logic [SUM_W-1:0]  w_sum_p0;
   logic [15:0]       w_fold_p0;
   logic [CNT_W-1:0]  w_cnt_inc;

   // Two end-around folds always suffice: after the first, a carry leaves a tiny low word.
   function automatic logic [15:0] fold16(input logic [SUM_W-1:0] s);
      logic [16:0] f;
      f = {1'b0, s[15:0]} + 17'(s[SUM_W-1:16]);
      return f[15:0] + 16'(f[16]);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign in_ready  = (r_state == ST_ACC);
   assign out_valid = (r_state == ST_DONE);
   assign w_accept  = in_valid && in_ready;
   assign w_take    = out_valid && out_ready;
   assign w_cnt_inc = sat_inc(r_cnt);

   always_comb begin
      w_data_p0 = in_data;
      if (in_last) begin
         for (int b = 0; b < NB; b++) begin
            if (!in_keep[b]) w_data_p0[b*8 +: 8] = 8'h00;
         end
      end
   end

   always_comb begin
      w_sum_p0 = SUM_W'(r_acc);
      for (int i = 0; i < W; i++) begin
         w_sum_p0 = w_sum_p0 + SUM_W'(w_data_p0[i*16 +: 16]);
      end
   end

   assign w_fold_p0 = fold16(w_sum_p0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACC:  if (w_accept && in_last) w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_ACC;
         default: w_state_nxt = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_ACC;
      else     r_state <= w_state_nxt;
   end

   // p0 -> p1: folded running sum and beat count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_fold_p0;
         r_cnt <= w_cnt_inc;
      end else if (w_take) begin
         r_acc <= '0;
         r_cnt <= '0;
      end
   end

   // p0 -> p1: result registers, loaded only by the accepted last beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_checksum <= '0;
         r_ok       <= 1'b0;
         r_beats    <= '0;
      end else if (w_accept && in_last) begin
         r_checksum <= ~w_fold_p0;
         r_ok       <= verify && (w_fold_p0 == 16'hFFFF);
         r_beats    <= w_cnt_inc;
      end
   end

   assign checksum = r_checksum;
   assign ok       = r_ok;
   assign beats    = r_beats;
endmodule
